operand_capture: RTL

OPERAND_CAPTURE -- requirements
Module: operand_capture

---
 rtl/lab_io_pkg.sv | 12 +
 rtl/button_debounce.sv | 85 ++++++++
 rtl/operand_capture.sv | 137 +++++++++++++
 3 files changed

// File: rtl/lab_io_pkg.sv
// Shared state encoding and default timing constant for the lab I/O front end.
package lab_io_pkg;

   localparam int DEBOUNCE_DEFAULT = 500000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      HOLD = 2'd2
   } op_state_e;

endpackage

// File: rtl/button_debounce.sv
// One active-low push-button: 2-flop synchronizer, level debouncer and a
// one-cycle press pulse on each debounced 1->0 transition.
module button_debounce
   import lab_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press,
   output logic level
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             meta_r;
   logic             sync_r;
   logic [1:0]       fill_r;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_next_s;
   logic             stable_r;
   logic             stable_next_s;
   logic             armed_r;
   logic             armed_next_s;
   logic             press_r;
   logic             press_next_s;

   // The stable level moves only after a full run of disagreeing samples
   always_comb begin
      cnt_next_s    = cnt_r;
      stable_next_s = stable_r;
      if (sync_r != stable_r) begin
         if (cnt_r >= CNT_LAST) begin
            stable_next_s = sync_r;
            cnt_next_s    = {CNT_W{1'b0}};
         end else if (cnt_r < CNT_MAX) begin
            cnt_next_s    = cnt_r + CNT_ONE;
         end else begin
            cnt_next_s    = CNT_MAX;
         end
      end else begin
         cnt_next_s = {CNT_W{1'b0}};
      end
   end

   // A press only counts once a real released sample has been seen since reset,
   // so a button held through reset cannot fire until released and pressed again
   always_comb begin
      if (fill_r[1] && sync_r && stable_r) begin
         armed_next_s = 1'b1;
      end else begin
         armed_next_s = armed_r;
      end
      press_next_s = armed_r & stable_r & ~stable_next_s;
   end

   // Synchronizer, debounce state and registered press pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r   <= 1'b1;
         sync_r   <= 1'b1;
         fill_r   <= 2'b00;
         cnt_r    <= {CNT_W{1'b0}};
         stable_r <= 1'b1;
         armed_r  <= 1'b0;
         press_r  <= 1'b0;
      end else begin
         meta_r   <= btn;
         sync_r   <= meta_r;
         fill_r   <= {fill_r[0], 1'b1};
         cnt_r    <= cnt_next_s;
         stable_r <= stable_next_s;
         armed_r  <= armed_next_s;
         press_r  <= press_next_s;
      end
   end

   assign press = press_r;
   assign level = stable_r;

endmodule

// File: rtl/operand_capture.sv
// Captures operands A/B from slider switches under push-button control and
// hands a one-cycle Start request to a downstream sequential unit.
module operand_capture
   import lab_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        LoadB,
   input  logic        Run,
   input  logic [15:0] SW,
   input  logic        Done,
   output logic [15:0] A,
   output logic [15:0] B,
   output logic        Start,
   output logic        Busy
);

   op_state_e   state_r;
   op_state_e   state_next_s;
   logic        load_ev_s;
   logic        run_ev_s;
   logic        run_level_s;
   logic [15:0] a_r;
   logic [15:0] a_next_s;
   logic [15:0] b_r;
   logic [15:0] b_next_s;
   logic        start_r;
   logic        start_next_s;
   logic        busy_r;
   logic        busy_next_s;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_loadb (
      .clk   (Clk),
      .rst_n (Reset),
      .btn   (LoadB),
      .press (load_ev_s),
      .level ()
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
      .clk   (Clk),
      .rst_n (Reset),
      .btn   (Run),
      .press (run_ev_s),
      .level (run_level_s)
   );

   // State register
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next state; a LoadB event on the same cycle swallows the Run event
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (run_ev_s && !load_ev_s) begin
               state_next_s = BUSY;
            end else begin
               state_next_s = IDLE;
            end
         end
         BUSY: begin
            if (Done) begin
               state_next_s = HOLD;
            end else begin
               state_next_s = BUSY;
            end
         end
         HOLD: begin
            if (run_level_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = HOLD;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      a_next_s     = a_r;
      b_next_s     = b_r;
      start_next_s = 1'b0;
      busy_next_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (load_ev_s) begin
               b_next_s = SW;
            end else if (run_ev_s) begin
               start_next_s = 1'b1;
               busy_next_s  = 1'b1;
            end else begin
               a_next_s = SW;
            end
         end
         BUSY: begin
            if (Done) begin
               busy_next_s = 1'b0;
            end else begin
               busy_next_s = 1'b1;
            end
         end
         HOLD:    busy_next_s = 1'b0;
         default: busy_next_s = 1'b0;
      endcase
   end

   // Output registers
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         a_r     <= 16'h0000;
         b_r     <= 16'h0000;
         start_r <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         a_r     <= a_next_s;
         b_r     <= b_next_s;
         start_r <= start_next_s;
         busy_r  <= busy_next_s;
      end
   end

   assign A     = a_r;
   assign B     = b_r;
   assign Start = start_r;
   assign Busy  = busy_r;

endmodule
